// File: rtl/sram_1p_port_arbiter.sv
// Shares one single-port SRAM between a read and a write requester, with a zeroing sweep
// after reset or flush, and a bounded write streak so pending reads are never starved.
module sram_1p_port_arbiter #(
   parameter int SETS          = 128,
   parameter int ADDR_W        = 7,
   parameter int DATA_W        = 80,
   parameter int WAYS          = 4,
   parameter int MAX_WR_STREAK = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   output logic              init_done,
   input  logic              rreq_valid,
   output logic              rreq_ready,
   input  logic [ADDR_W-1:0] rreq_addr,
   output logic              rresp_valid,
   output logic [DATA_W-1:0] rresp_data,
   input  logic              wreq_valid,
   output logic              wreq_ready,
   input  logic [ADDR_W-1:0] wreq_addr,
   input  logic [DATA_W-1:0] wreq_data,
   input  logic [WAYS-1:0]   wreq_mask,
   output logic [ADDR_W-1:0] sram_r_addr,
   input  logic [DATA_W-1:0] sram_r_data,
   output logic              sram_w_en,
   output logic [ADDR_W-1:0] sram_w_addr,
   output logic [DATA_W-1:0] sram_w_data,
   output logic [WAYS-1:0]   sram_w_mask
);

   localparam int STREAK_W = $clog2(MAX_WR_STREAK + 1);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_init_cnt;
   logic [STREAK_W-1:0] r_streak;
   logic                r_rresp_valid;

   logic w_run;
   logic w_streak_full;
   logic w_wr_grant;
   logic w_rd_grant;

   // A write wins a contested cycle only until the streak budget is spent.
   always_comb begin
      w_run         = (r_state == ST_RUN);
      w_streak_full = (r_streak >= STREAK_W'(MAX_WR_STREAK));
      w_wr_grant    = w_run && wreq_valid && (!rreq_valid || !w_streak_full);
      w_rd_grant    = w_run && rreq_valid && !w_wr_grant;
   end

   assign init_done   = w_run;
   assign rreq_ready  = w_rd_grant;
   assign wreq_ready  = w_wr_grant;
   assign rresp_valid = r_rresp_valid;
   assign rresp_data  = sram_r_data;

   // The sweep owns the write port in INIT, writing zeros to every way.
   assign sram_r_addr = w_run ? rreq_addr : r_init_cnt;
   assign sram_w_en   = !w_run || w_wr_grant;
   assign sram_w_addr = w_run ? wreq_addr : r_init_cnt;
   assign sram_w_data = w_run ? wreq_data : '0;
   assign sram_w_mask = w_run ? wreq_mask : '1;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_INIT;
         r_init_cnt    <= '0;
         r_streak      <= '0;
         r_rresp_valid <= 1'b0;
      end else begin
         r_rresp_valid <= w_rd_grant;
         case (r_state)
            ST_INIT: begin
               r_streak <= '0;
               if (r_init_cnt == ADDR_W'(SETS - 1)) begin
                  r_state    <= ST_RUN;
                  r_init_cnt <= '0;
               end else begin
                  r_init_cnt <= r_init_cnt + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               if (w_rd_grant || !rreq_valid) begin
                  r_streak <= '0;
               end else if (w_wr_grant && !w_streak_full) begin
                  r_streak <= r_streak + STREAK_W'(1);
               end
               // Requests granted in the flush cycle still complete; the sweep starts next cycle.
               if (flush) begin
                  r_state    <= ST_INIT;
                  r_init_cnt <= '0;
               end
            end
            default: begin
               r_state    <= ST_INIT;
               r_init_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_1p_port_arbiter.sv
// Directed bench for sram_1p_port_arbiter with a behavioural 128x80 masked SRAM behind it.
module tb_sram_1p_port_arbiter;

   localparam int SETS   = 128;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 80;
   localparam int WAYS   = 4;
   localparam int WAY_W  = DATA_W / WAYS;

   logic              clock;
   logic              reset;
   logic              flush;
   logic              init_done;
   logic              rreq_valid;
   logic              rreq_ready;
   logic [ADDR_W-1:0] rreq_addr;
   logic              rresp_valid;
   logic [DATA_W-1:0] rresp_data;
   logic              wreq_valid;
   logic              wreq_ready;
   logic [ADDR_W-1:0] wreq_addr;
   logic [DATA_W-1:0] wreq_data;
   logic [WAYS-1:0]   wreq_mask;
   logic [ADDR_W-1:0] sram_r_addr;
   logic [DATA_W-1:0] sram_r_data;
   logic              sram_w_en;
   logic [ADDR_W-1:0] sram_w_addr;
   logic [DATA_W-1:0] sram_w_data;
   logic [WAYS-1:0]   sram_w_mask;

   logic [DATA_W-1:0] mem [SETS];

   int n_vec;
   int n_miss;

   sram_1p_port_arbiter dut (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .init_done   (init_done),
      .rreq_valid  (rreq_valid),
      .rreq_ready  (rreq_ready),
      .rreq_addr   (rreq_addr),
      .rresp_valid (rresp_valid),
      .rresp_data  (rresp_data),
      .wreq_valid  (wreq_valid),
      .wreq_ready  (wreq_ready),
      .wreq_addr   (wreq_addr),
      .wreq_data   (wreq_data),
      .wreq_mask   (wreq_mask),
      .sram_r_addr (sram_r_addr),
      .sram_r_data (sram_r_data),
      .sram_w_en   (sram_w_en),
      .sram_w_addr (sram_w_addr),
      .sram_w_data (sram_w_data),
      .sram_w_mask (sram_w_mask)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-port SRAM: a write cycle performs no read; read data appears one cycle later.
   always @(posedge clock) begin
      if (sram_w_en) begin
         for (int w = 0; w < WAYS; w++) begin
            if (sram_w_mask[w]) mem[sram_w_addr][w*WAY_W +: WAY_W] <= sram_w_data[w*WAY_W +: WAY_W];
         end
      end else begin
         sram_r_data <= mem[sram_r_addr];
      end
   end

   task automatic check_vec(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic rv, input logic [ADDR_W-1:0] ra, input logic wv,
                        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic [WAYS-1:0] wm, input logic fl);
      @(posedge clock);
      #1;
      rreq_valid = rv;
      rreq_addr  = ra;
      wreq_valid = wv;
      wreq_addr  = wa;
      wreq_data  = wd;
      wreq_mask  = wm;
      flush      = fl;
   endtask

   localparam logic [DATA_W-1:0] D3      = 80'h12345_6789A_BCDEF_01111;
   localparam logic [DATA_W-1:0] D3_MRG  = 80'h12345_6789A_FFFFF_01111;
   localparam logic [DATA_W-1:0] D9_PART = 80'h00000_FFFFF_00000_FFFFF;
   localparam logic [DATA_W-1:0] ONES    = {DATA_W{1'b1}};

   initial begin
      int  n_reads;
      logic exp_w;
      logic exp_prev_r;
      n_vec      = 0;
      n_miss     = 0;
      reset      = 1'b1;
      flush      = 1'b0;
      rreq_valid = 1'b0;
      rreq_addr  = '0;
      wreq_valid = 1'b0;
      wreq_addr  = '0;
      wreq_data  = '0;
      wreq_mask  = '0;

      // Reset state
      @(posedge clock);
      @(negedge clock);
      check_vec("rst_rvld", 80'(rresp_valid), 80'd0);
      check_vec("rst_done", 80'(init_done), 80'd0);
      check_vec("rst_waddr", 80'(sram_w_addr), 80'd0);
      @(posedge clock);
      #1 reset = 1'b0;

      // Initial sweep
      for (int i = 0; i < SETS; i++) begin
         @(negedge clock);
         check_vec("sweep_waddr", 80'(sram_w_addr), 80'(i));
         check_vec("sweep_wen", 80'(sram_w_en), 80'd1);
         check_vec("sweep_done", 80'(init_done), 80'd0);
      end
      @(negedge clock);
      check_vec("sweep_end_done", 80'(init_done), 80'd1);

      // Read of set 5 returns the swept zeros
      drive(1'b1, 7'd5, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("rd5_ready", 80'(rreq_ready), 80'd1);
      check_vec("rd5_wen", 80'(sram_w_en), 80'd0);
      check_vec("rd5_raddr", 80'(sram_r_addr), 80'd5);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("rd5_rvld", 80'(rresp_valid), 80'd1);
      check_vec("rd5_data", rresp_data, 80'd0);

      // Full write then read-after-write of set 3
      drive(1'b0, 7'd0, 1'b1, 7'd3, D3, 4'b1111, 1'b0);
      @(negedge clock);
      check_vec("wr3_ready", 80'(wreq_ready), 80'd1);
      check_vec("wr3_waddr", 80'(sram_w_addr), 80'd3);
      check_vec("wr3_wdata", sram_w_data, D3);
      check_vec("wr3_rvld", 80'(rresp_valid), 80'd0);
      drive(1'b1, 7'd3, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("rd3_ready", 80'(rreq_ready), 80'd1);
      check_vec("rd3_wready", 80'(wreq_ready), 80'd0);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("rd3_rvld", 80'(rresp_valid), 80'd1);
      check_vec("rd3_data", rresp_data, D3);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("idle_rvld", 80'(rresp_valid), 80'd0);
      check_vec("idle_wen", 80'(sram_w_en), 80'd0);

      // Masked merge into set 3 (way 1 only)
      drive(1'b0, 7'd0, 1'b1, 7'd3, ONES, 4'b0010, 1'b0);
      drive(1'b1, 7'd3, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("mrg3_data", rresp_data, D3_MRG);

      // Partial mask on a zeroed set
      drive(1'b0, 7'd0, 1'b1, 7'd9, ONES, 4'b0101, 1'b0);
      @(negedge clock);
      check_vec("wr9_mask", 80'(sram_w_mask), 80'h5);
      drive(1'b1, 7'd9, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("rd9_rvld", 80'(rresp_valid), 80'd1);
      check_vec("rd9_data", rresp_data, D9_PART);

      // Starvation guard: W,W,W,W,R repeating
      drive(1'b1, 7'd3, 1'b1, 7'd20, '0, 4'b1111, 1'b0);
      n_reads    = 0;
      exp_prev_r = 1'b0;
      for (int c = 0; c < 15; c++) begin
         if (c > 0) @(posedge clock);
         @(negedge clock);
         exp_w = ((c % 5) != 4);
         check_vec("strv_wready", 80'(wreq_ready), 80'(exp_w));
         check_vec("strv_rready", 80'(rreq_ready), 80'(!exp_w));
         check_vec("strv_rvld", 80'(rresp_valid), 80'(exp_prev_r));
         if (exp_prev_r) check_vec("strv_rdata", rresp_data, D3_MRG);
         if (rreq_ready) n_reads++;
         exp_prev_r = !exp_w;
      end
      check_vec("strv_nreads", 80'(n_reads), 80'd3);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("strv_last_rvld", 80'(rresp_valid), 80'd1);

      // Flush in the same cycle as a read grant
      drive(1'b1, 7'd9, 1'b0, 7'd0, '0, 4'd0, 1'b1);
      @(negedge clock);
      check_vec("fl_rready", 80'(rreq_ready), 80'd1);
      check_vec("fl_done", 80'(init_done), 80'd1);
      drive(1'b1, 7'd9, 1'b1, 7'd20, ONES, 4'b1111, 1'b0);
      @(negedge clock);
      check_vec("fl_rvld", 80'(rresp_valid), 80'd1);
      check_vec("fl_rdata", rresp_data, D9_PART);
      check_vec("fl_init_done", 80'(init_done), 80'd0);
      check_vec("fl_waddr0", 80'(sram_w_addr), 80'd0);
      check_vec("fl_wdata0", sram_w_data, 80'd0);
      check_vec("fl_rready0", 80'(rreq_ready), 80'd0);
      check_vec("fl_wready0", 80'(wreq_ready), 80'd0);
      for (int i = 1; i < SETS; i++) begin
         @(negedge clock);
         check_vec("fl_waddr", 80'(sram_w_addr), 80'(i));
         check_vec("fl_rready", 80'(rreq_ready), 80'd0);
         check_vec("fl_wready", 80'(wreq_ready), 80'd0);
      end
      @(negedge clock);
      check_vec("fl_end_done", 80'(init_done), 80'd1);
      check_vec("fl_end_wready", 80'(wreq_ready), 80'd1);
      drive(1'b1, 7'd9, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b0);
      @(negedge clock);
      check_vec("fl_rd9_rvld", 80'(rresp_valid), 80'd1);
      check_vec("fl_rd9_zero", rresp_data, 80'd0);

      // Reset mid-sweep at set 60 (with an ignored flush at set 30)
      drive(1'b0, 7'd0, 1'b0, 7'd0, '0, 4'd0, 1'b1);
      drive(1'b1, 7'd0, 1'b1, 7'd0, '0, 4'b1111, 1'b0);
      for (int i = 0; i <= 60; i++) begin
         @(negedge clock);
         check_vec("rs_pre_waddr", 80'(sram_w_addr), 80'(i));
         check_vec("rs_pre_wready", 80'(wreq_ready), 80'd0);
         flush = (i == 30);
      end
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      for (int i = 0; i < SETS; i++) begin
         @(negedge clock);
         check_vec("rs_waddr", 80'(sram_w_addr), 80'(i));
         check_vec("rs_rready", 80'(rreq_ready), 80'd0);
         check_vec("rs_wready", 80'(wreq_ready), 80'd0);
         check_vec("rs_done", 80'(init_done), 80'd0);
      end
      @(negedge clock);
      check_vec("rs_end_done", 80'(init_done), 80'd1);
      check_vec("rs_end_wready", 80'(wreq_ready), 80'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/sram_1p_port_arbiter.md
Name: sram_1p_port_arbiter

Overview:
- Sits in front of a single-port 128-set x 80-bit SRAM wrapper. The wrapper has 4 ways of 20 bits, a per-way write mask, and write-over-read priority.
- Shares the single SRAM port between one read requester and one write requester, using valid/ready handshakes.
- After reset, and on flush request, sequences a zero-initialisation sweep over all sets.
- Prevents write streams from starving reads.

Parameters:
- SETS, 128, number of SRAM sets.
- ADDR_W, 7, set address width (log2 SETS).
- DATA_W, 80, SRAM row width.
- WAYS, 4, write-mask width; way w occupies data bits [w*DATA_W/WAYS +: DATA_W/WAYS].
- MAX_WR_STREAK, 4, maximum consecutive write grants while a read is pending.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pulse; requests a re-initialisation sweep
- init_done  out  1  high when not sweeping
- rreq_valid  in  1  read request valid
- rreq_ready  out  1  read request accepted this cycle
- rreq_addr  in  ADDR_W  read set address
- rresp_valid  out  1  read data valid (single-cycle pulse, no backpressure)
- rresp_data  out  DATA_W  read data
- wreq_valid  in  1  write request valid
- wreq_ready  out  1  write request accepted this cycle
- wreq_addr  in  ADDR_W  write set address
- wreq_data  in  DATA_W  write data
- wreq_mask  in  WAYS  per-way write enable
- sram_r_addr  out  ADDR_W  to SRAM read address
- sram_r_data  in  DATA_W  from SRAM; valid 1 cycle after a read cycle
- sram_w_en  out  1  to SRAM write enable
- sram_w_addr  out  ADDR_W  to SRAM write address
- sram_w_data  out  DATA_W  to SRAM write data
- sram_w_mask  out  WAYS  to SRAM write mask

Behaviour:
- States: INIT, RUN. Reset → INIT with init_cnt=0, streak=0, rresp_valid=0.
- Reset asserted mid-sweep or mid-run restarts INIT at set 0. Any in-flight read response is dropped: rresp_valid=0 in the cycle after reset.

INIT:
- Each cycle: sram_w_en=1, sram_w_addr=init_cnt, sram_w_data=0, sram_w_mask=all ones, init_cnt++.
- rreq_ready=0, wreq_ready=0, init_done=0.
- After writing set SETS-1 (cycle SETS-1 of the sweep) → RUN. init_done=1 from the next cycle.
- A sweep takes exactly SETS cycles. flush during INIT is ignored.

RUN:
- Grant rules, evaluated combinationally each cycle:
  - Only wreq_valid: write granted.
  - Only rreq_valid: read granted.
  - Both valid: write granted if streak < MAX_WR_STREAK, otherwise read granted.
  - Neither valid: idle, sram_w_en=0.
- Write grant: wreq_ready=1, sram_w_en=1, sram_w_addr/data/mask = wreq_addr/data/mask.
- Read grant: rreq_ready=1, sram_w_en=0, sram_r_addr=rreq_addr.
- sram_r_addr always carries rreq_addr in RUN, and init_cnt in INIT.
- Ready signals never assert without the corresponding valid.
- streak:
  - Increments (saturating at MAX_WR_STREAK) when a write is granted while rreq_valid=1.
  - Clears on any read grant, or on any cycle with rreq_valid=0.
- Read response: rresp_valid=1 exactly one cycle after a read grant, with rresp_data=sram_r_data in that cycle. Otherwise rresp_valid=0 and rresp_data is don't-care.
- Read/write ordering: a read granted the cycle after a write to the same set returns the merged new data. Unmasked ways keep their old value.
- flush in RUN:
  - The next cycle enters INIT with init_cnt=0.
  - A request granted in the flush cycle itself completes normally.
  - A read granted in the flush cycle still produces its rresp_valid pulse, in the first INIT cycle.
- Simultaneous flush and reset: reset wins; the result is identical.

Test Plan:
- Reset for 2 cycles, then release with no requests → init_done=0 for 128 cycles with sram_w_en=1 and addresses 0..127 in order; init_done=1 on cycle 128. A subsequent read of set 5 returns 0 after 1 cycle.
- In RUN: write set 3, data 0x1234_5678_9ABC_DEF0_1111, mask 4'b1111; next cycle read set 3 → rresp_valid pulses 1 cycle after the read grant with that data.
- Partial mask: write set 9 with all-ones data and mask 4'b0101, then read set 9 → bits [19:0] and [59:40] are ones, all other bits are 0.
- Starvation: hold wreq_valid and rreq_valid high continuously, MAX_WR_STREAK=4 → grant pattern W,W,W,W,R repeating. Exactly one read grant occurs every 5 cycles.
- flush while a read is granted in the same cycle → rresp_valid pulses in the next cycle, then 128 INIT cycles follow with both readies low; init_done returns high afterward.
- Assert reset at INIT set 60 → the sweep restarts at set 0, and the full 128-cycle sweep completes before any ready asserts.
